// File: rtl/rx_pkg.sv
// Shared receive-path definitions: FSM encodings for the phase selector and
// small arithmetic helpers reused by metric/AGC style blocks.
package rx_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_SYNC = 3'd1;
    localparam logic [2:0] ST_ACCUM     = 3'd2;
    localparam logic [2:0] ST_COMPARE   = 3'd3;
    localparam logic [2:0] ST_UPDATE    = 3'd4;

    localparam int unsigned MAG_W = 32;

    // Window sums of 2^log2_nsym magnitudes, each at most 2^(nb-1), never reach 2^(nb+log2_nsym).
    function automatic int unsigned nb_acc(input int unsigned nb, input int unsigned log2_nsym);
        return nb + log2_nsym;
    endfunction

    // Caller sign-extends into MAG_W bits and keeps the low NB bits, so the
    // most negative input maps to 2^(NB-1) without saturation.
    function automatic logic [MAG_W-1:0] abs_mag(input logic signed [MAG_W-1:0] x);
        return x[MAG_W-1] ? $unsigned(-x) : $unsigned(x);
    endfunction

endpackage

// File: rtl/phase_energy_bank.sv
// Bank of per-phase energy accumulators with synchronous clear and a single
// add port steered by the current sample phase.
module phase_energy_bank
    import rx_pkg::*;
#(
    parameter int unsigned NB     = 8,
    parameter int unsigned OS     = 4,
    parameter int unsigned NB_OFS = 2,
    parameter int unsigned NB_ACC = nb_acc(8, 10)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         i_clear,
    input  logic                         i_add_en,
    input  logic [NB_OFS-1:0]            i_add_phase,
    input  logic [NB-1:0]                i_mag,
    output logic [OS-1:0][NB_ACC-1:0]    o_acc
);

    for (genvar p = 0; p < OS; p++) begin : g_acc
        logic [NB_ACC-1:0] r_acc;

        always_ff @(posedge clock) begin
            if (reset || i_clear) begin
                r_acc <= '0;
            end else if (i_add_en && (i_add_phase == NB_OFS'(p))) begin
                r_acc <= r_acc + NB_ACC'(i_mag);
            end
        end

        assign o_acc[p] = r_acc;
    end

endmodule

// File: rtl/rx_phase_sync.sv
// Automatic sampling-phase selector: integrates |sample| per phase over a
// window of symbols, picks the strongest phase and slices the bit there.
module rx_phase_sync
    import rx_pkg::*;
#(
    parameter int unsigned NB        = 8,
    parameter int unsigned OS        = 4,
    parameter int unsigned NB_OFS    = 2,
    parameter int unsigned LOG2_NSYM = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_enable,
    input  logic                 i_valid,
    input  logic signed [NB-1:0] i_sample,
    output logic [NB_OFS-1:0]    o_offset,
    output logic                 o_locked,
    output logic                 o_bit,
    output logic                 o_bit_valid
);

    localparam int unsigned       NB_ACC  = nb_acc(NB, LOG2_NSYM);
    localparam logic [NB_OFS-1:0] LAST_PH = NB_OFS'(OS - 1);

    logic [2:0]                 r_state;
    logic [2:0]                 w_state_d;
    logic [NB_OFS-1:0]          r_phase;
    logic [NB_OFS-1:0]          w_phase;
    logic [LOG2_NSYM-1:0]       r_sym_cnt;
    logic [NB_OFS-1:0]          r_cmp_idx;
    logic [NB_ACC-1:0]          r_max;
    logic [NB_OFS-1:0]          r_best;
    logic [NB_OFS-1:0]          r_offset;
    logic                       r_locked;
    logic                       r_bit;
    logic                       r_bit_valid;
    logic [NB-1:0]              w_mag;
    logic                       w_add_en;
    logic                       w_clear;
    logic                       w_last_sym;
    logic [OS-1:0][NB_ACC-1:0]  w_acc;
    logic [NB_ACC-1:0]          w_cmp_acc;

    // Phase of the sample on the input this cycle; the strobe cycle is phase 0.
    assign w_phase    = i_valid ? '0 : ((r_phase == LAST_PH) ? '0 : r_phase + NB_OFS'(1));
    assign w_mag      = NB'(abs_mag(32'(i_sample)));
    assign w_last_sym = (w_phase == LAST_PH) && (r_sym_cnt == '1);
    assign w_cmp_acc  = w_acc[r_cmp_idx];

    always_comb begin
        w_state_d = r_state;
        w_add_en  = 1'b0;
        w_clear   = 1'b0;
        if (!i_enable) begin
            w_state_d = ST_IDLE;
            w_clear   = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_clear   = 1'b1;
                    w_state_d = ST_WAIT_SYNC;
                end
                ST_WAIT_SYNC: begin
                    if (i_valid) begin
                        w_add_en  = 1'b1;
                        w_state_d = ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    w_add_en = 1'b1;
                    if (w_last_sym) begin
                        w_state_d = ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (r_cmp_idx == LAST_PH) begin
                        w_state_d = ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    w_clear   = 1'b1;
                    w_state_d = ST_WAIT_SYNC;
                end
                default: begin
                    w_clear   = 1'b1;
                    w_state_d = ST_IDLE;
                end
            endcase
        end
    end

    phase_energy_bank #(
        .NB     (NB),
        .OS     (OS),
        .NB_OFS (NB_OFS),
        .NB_ACC (NB_ACC)
    ) u_bank (
        .clock       (clock),
        .reset       (reset),
        .i_clear     (w_clear),
        .i_add_en    (w_add_en),
        .i_add_phase (w_phase),
        .i_mag       (w_mag),
        .o_acc       (w_acc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_phase     <= '0;
            r_sym_cnt   <= '0;
            r_cmp_idx   <= '0;
            r_max       <= '0;
            r_best      <= '0;
            r_offset    <= '0;
            r_locked    <= 1'b0;
            r_bit       <= 1'b0;
            r_bit_valid <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_phase <= w_phase;

            if (w_clear) begin
                r_sym_cnt <= '0;
            end else if (w_add_en && (w_phase == LAST_PH)) begin
                r_sym_cnt <= r_sym_cnt + LOG2_NSYM'(1);
            end

            // Strictly-greater update keeps the lowest phase on ties.
            if ((r_state == ST_COMPARE) && i_enable) begin
                r_cmp_idx <= r_cmp_idx + NB_OFS'(1);
                if ((r_cmp_idx == '0) || (w_cmp_acc > r_max)) begin
                    r_max  <= w_cmp_acc;
                    r_best <= r_cmp_idx;
                end
            end else begin
                r_cmp_idx <= '0;
            end

            if (!i_enable) begin
                r_locked <= 1'b0;
            end else if (r_state == ST_UPDATE) begin
                r_offset <= r_best;
                r_locked <= 1'b1;
            end

            if (i_enable && (r_state != ST_IDLE) && (w_phase == r_offset)) begin
                r_bit       <= i_sample[NB-1];
                r_bit_valid <= 1'b1;
            end else begin
                r_bit_valid <= 1'b0;
            end
        end
    end

    assign o_offset    = r_offset;
    assign o_locked    = r_locked;
    assign o_bit       = r_bit;
    assign o_bit_valid = r_bit_valid;

endmodule

// File: tb/tb_rx_phase_sync.sv
// Bench for rx_phase_sync: directed scenarios with randomized sample signs and
// amplitudes, checked every cycle against a window-level behavioural model.
module tb_rx_phase_sync;

    localparam int NB        = 8;
    localparam int OS        = 4;
    localparam int NB_OFS    = 2;
    localparam int LOG2_NSYM = 4;
    localparam int NSYM      = 16;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 i_enable;
    logic                 i_valid;
    logic signed [NB-1:0] i_sample;
    logic [NB_OFS-1:0]    o_offset;
    logic                 o_locked;
    logic                 o_bit;
    logic                 o_bit_valid;
    logic [NB_OFS-1:0]    b_offset;
    logic                 b_locked;
    logic                 b_bit;
    logic                 b_bit_valid;

    rx_phase_sync #(
        .NB        (NB),
        .OS        (OS),
        .NB_OFS    (NB_OFS),
        .LOG2_NSYM (LOG2_NSYM)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .i_enable    (i_enable),
        .i_valid     (i_valid),
        .i_sample    (i_sample),
        .o_offset    (o_offset),
        .o_locked    (o_locked),
        .o_bit       (o_bit),
        .o_bit_valid (o_bit_valid)
    );

    // Long-window instance exercising the full-width accumulator.
    rx_phase_sync #(
        .NB        (NB),
        .OS        (OS),
        .NB_OFS    (NB_OFS),
        .LOG2_NSYM (10)
    ) u_big (
        .clock       (clock),
        .reset       (reset),
        .i_enable    (i_enable),
        .i_valid     (i_valid),
        .i_sample    (i_sample),
        .o_offset    (b_offset),
        .o_locked    (b_locked),
        .o_bit       (b_bit),
        .o_bit_valid (b_bit_valid)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    int g_ph;
    int amp [OS];
    bit rnd_sign;

    // Reference model: running = enabled and past the idle cycle; collecting =
    // inside a window; m_cd counts the cycles left until the new offset lands.
    bit m_run, m_collect, m_locked, m_bit, m_bv;
    int m_cd, m_syms, m_ph, m_offset;
    int m_sum [OS];

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int best_phase();
        int b = 0;
        for (int p = 1; p < OS; p++) if (m_sum[p] > m_sum[b]) b = p;
        return b;
    endfunction

    task automatic model_clear();
        for (int p = 0; p < OS; p++) m_sum[p] = 0;
        m_syms = 0;
    endtask

    task automatic model_step();
        int s  = int'(i_sample);
        int ph = i_valid ? 0 : (m_ph + 1) % OS;
        if (reset) begin
            m_run = 0; m_collect = 0; m_cd = 0; model_clear();
            m_offset = 0; m_locked = 0; m_bit = 0; m_bv = 0; ph = 0;
        end else if (!i_enable) begin
            m_run = 0; m_collect = 0; m_cd = 0; model_clear();
            m_locked = 0; m_bv = 0;
        end else begin
            if (m_run && ph == m_offset) begin
                m_bit = (s < 0); m_bv = 1;
            end else begin
                m_bv = 0;
            end
            if (!m_run) begin
                m_run = 1;
            end else if (m_cd > 0) begin
                m_cd--;
                if (m_cd == 0) begin
                    m_offset = best_phase(); m_locked = 1; model_clear();
                end
            end else begin
                if (!m_collect && i_valid) m_collect = 1;
                if (m_collect) begin
                    m_sum[ph] += (s < 0) ? -s : s;
                    if (ph == OS - 1) begin
                        m_syms++;
                        if (m_syms == NSYM) begin
                            m_collect = 0; m_cd = OS + 1;
                        end
                    end
                end
            end
        end
        m_ph = ph;
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        check("offset", int'(o_offset), m_offset);
        check("locked", int'(o_locked), int'(m_locked));
        check("bit", int'(o_bit), int'(m_bit));
        check("bit_valid", int'(o_bit_valid), int'(m_bv));
    endtask

    task automatic drive_one(input int v);
        i_valid  = (g_ph == 0);
        i_sample = NB'(v);
        tick();
        g_ph = (g_ph + 1) % OS;
    endtask

    task automatic drive_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            int v = amp[g_ph];
            if (rnd_sign && $urandom_range(0, 1) == 1) v = -v;
            drive_one(v);
        end
    endtask

    task automatic set_amp(input int a0, input int a1, input int a2, input int a3);
        amp[0] = a0; amp[1] = a1; amp[2] = a2; amp[3] = a3;
    endtask

    task automatic do_reset();
        reset = 1'b1; i_enable = 1'b0;
        drive_cycles(2);
        reset = 1'b0;
        check("rst_offset", int'(o_offset), 0);
        check("rst_locked", int'(o_locked), 0);
        check("rst_bit", int'(o_bit), 0);
        check("rst_bit_valid", int'(o_bit_valid), 0);
        g_ph = 1;
    endtask

    int bvals [3] = '{-5, 7, -1};
    int strobes;

    initial begin
        reset = 1'b1; i_enable = 1'b0; i_valid = 1'b0; i_sample = '0;
        g_ph = 0; rnd_sign = 1'b0; m_ph = 0;
        set_amp(0, 0, 0, 0);

        // Energy peak at phase 2; lock lands OS+1 cycles after edge T.
        do_reset();
        set_amp(20, 20, 100, 20); rnd_sign = 1'b1; i_enable = 1'b1;
        drive_cycles(71);
        check("peak_not_yet_locked", int'(o_locked), 0);
        drive_cycles(1);
        check("peak_locked", int'(o_locked), 1);
        check("peak_offset", int'(o_offset), 2);

        // Bit slicing at the locked phase.
        while (g_ph != 0) drive_one(20);
        for (int s = 0; s < 3; s++) begin
            strobes = 0;
            for (int p = 0; p < OS; p++) begin
                drive_one((p == 2) ? bvals[s] : 20);
                if (o_bit_valid) strobes++;
                if (p == 2) begin
                    check("bit_strobe", int'(o_bit_valid), 1);
                    check("bit_value", int'(o_bit), (bvals[s] < 0) ? 1 : 0);
                end
            end
            check("strobes_per_symbol", strobes, 1);
        end

        // Ties resolve to the lowest phase, then a one-LSB lead wins.
        do_reset();
        set_amp(50, 50, 50, 50); rnd_sign = 1'b0; i_enable = 1'b1;
        drive_cycles(72);
        check("tie_offset", int'(o_offset), 0);
        amp[3] = 51;
        drive_cycles(72);
        check("tie_break_offset", int'(o_offset), 3);

        // Reset in the middle of symbol 9 forces a full fresh window.
        do_reset();
        set_amp(20, 20, 100, 20); rnd_sign = 1'b1; i_enable = 1'b1;
        drive_cycles(36);
        reset = 1'b1;
        drive_cycles(1);
        reset = 1'b0;
        check("midrst_locked", int'(o_locked), 0);
        check("midrst_bit_valid", int'(o_bit_valid), 0);
        drive_cycles(70);
        check("midrst_not_yet_locked", int'(o_locked), 0);
        drive_cycles(1);
        check("midrst_locked_again", int'(o_locked), 1);
        check("midrst_offset", int'(o_offset), 2);

        // Enable dropped during COMPARE keeps the previous offset.
        do_reset();
        set_amp(20, 20, 100, 20); rnd_sign = 1'b1; i_enable = 1'b1;
        drive_cycles(72);
        check("dis_first_offset", int'(o_offset), 2);
        set_amp(100, 20, 20, 20);
        drive_cycles(68);
        i_enable = 1'b0;
        drive_cycles(1);
        check("dis_locked", int'(o_locked), 0);
        check("dis_offset", int'(o_offset), 2);
        check("dis_bit_valid", int'(o_bit_valid), 0);
        drive_cycles(5);
        check("dis_offset_hold", int'(o_offset), 2);

        // Early strobe: a three-sample symbol is not counted.
        do_reset();
        set_amp(20, 100, 20, 20); rnd_sign = 1'b1; i_enable = 1'b1;
        drive_cycles(19);
        drive_cycles(3);
        g_ph = 0;
        drive_cycles(52);
        check("early_not_yet_locked", int'(o_locked), 0);
        drive_cycles(1);
        check("early_locked", int'(o_locked), 1);
        check("early_offset", int'(o_offset), 1);

        // Extreme magnitudes; long window reaches 131072 in phase 1.
        do_reset();
        set_amp(127, -128, 127, 127); rnd_sign = 1'b0; i_enable = 1'b1;
        drive_cycles(4103);
        check("big_not_yet_locked", int'(b_locked), 0);
        check("extreme_offset", int'(o_offset), 1);
        drive_cycles(1);
        check("big_locked", int'(b_locked), 1);
        check("big_offset", int'(b_offset), 1);

        // Random amplitudes and signs over several windows.
        do_reset();
        rnd_sign = 1'b1; i_enable = 1'b1;
        for (int w = 0; w < 4; w++) begin
            for (int p = 0; p < OS; p++) amp[p] = $urandom_range(0, 127);
            drive_cycles(72);
        end
        check("rand_locked", int'(o_locked), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
